// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
//
// Shares one external memory command/data port between the I-cache refill
// path and the D-cache refill/write-back path. It accepts one burst at a
// time and arbitrates round-robin when both sides ask at once. It then
// issues the memory command, streams write-back data, and routes read beats
// back to the requester that owns the burst.
//
// Ports:
//   CLK, reset_n           clock (rising edge), async active-low reset
//   ic_req_*               I-side refill request (always a read)
//   ic_resp_*              I-side read beats, last flag on the final beat
//   dc_req_*               D-side request, dc_req_rnw = 1 read / 0 write-back
//   dc_wdata*              D-side write-back beat stream
//   dc_resp_*              D-side read beats, last flag on the final beat
//   mem_cmd_*              burst command to the memory controller
//   mem_wdata*             write beats to the memory controller
//   mem_rdata*             read beats from the memory controller (no stall)
//   busy                   a burst is in progress
//   owner                  current or most recent grant, 0 = I, 1 = D

module cache_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int BEATS  = 4
) (
  input  logic              CLK,
  input  logic              reset_n,
  input  logic              ic_req_valid,
  input  logic [ADDR_W-1:0] ic_req_addr,
  output logic              ic_req_ready,
  output logic              ic_resp_valid,
  output logic [DATA_W-1:0] ic_resp_data,
  output logic              ic_resp_last,
  input  logic              dc_req_valid,
  input  logic              dc_req_rnw,
  input  logic [ADDR_W-1:0] dc_req_addr,
  output logic              dc_req_ready,
  input  logic [DATA_W-1:0] dc_wdata,
  input  logic              dc_wdata_valid,
  output logic              dc_wdata_ready,
  output logic              dc_resp_valid,
  output logic [DATA_W-1:0] dc_resp_data,
  output logic              dc_resp_last,
  output logic              mem_cmd_valid,
  input  logic              mem_cmd_ready,
  output logic              mem_cmd_rnw,
  output logic [ADDR_W-1:0] mem_cmd_addr,
  output logic              mem_wdata_valid,
  input  logic              mem_wdata_ready,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rdata_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  localparam int CNT_W = $clog2(BEATS);
  localparam int OFF_W = $clog2(BEATS * DATA_W / 8);

  typedef enum logic [1:0] {IDLE, CMD, WR, RD} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rnw_q, rnw_d;
  // owner_q doubles as the round-robin "last owner": both are updated on
  // every grant and both reset to 0, so one flop carries both meanings.
  logic              owner_q, owner_d;

  logic              grant_any;
  logic              grant_dc;
  logic              wr_xfer;
  logic              rd_beat;
  logic              last_cnt;
  logic [ADDR_W-1:0] sel_addr;

  // Grant logic. A tie goes to the side that did not win last time; with
  // owner_q reset to 0 the D-side wins the first tie. Readiness is masked
  // while reset is held so nothing is accepted during reset.
  always_comb begin
    grant_any = reset_n && (state_q == IDLE) && (ic_req_valid || dc_req_valid);
    grant_dc  = dc_req_valid && (!ic_req_valid || !owner_q);
    sel_addr  = grant_dc ? dc_req_addr : ic_req_addr;
    wr_xfer   = (state_q == WR) && dc_wdata_valid && mem_wdata_ready;
    rd_beat   = (state_q == RD) && mem_rdata_valid;
    last_cnt  = (cnt_q == CNT_W'(BEATS - 1));
  end

  // Next-state logic. The beat counter is cleared on every exit to IDLE, so
  // it never wraps inside a burst.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rnw_d   = rnw_q;
    owner_d = owner_q;
    case (state_q)
      IDLE: begin
        if (grant_any) begin
          addr_d  = {sel_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          rnw_d   = grant_dc ? dc_req_rnw : 1'b1;
          owner_d = grant_dc;
          state_d = CMD;
        end
      end
      CMD: begin
        if (mem_cmd_ready) begin
          cnt_d   = '0;
          state_d = rnw_q ? RD : WR;
        end
      end
      WR: begin
        if (wr_xfer) begin
          if (last_cnt) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      RD: begin
        if (rd_beat) begin
          if (last_cnt) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rnw_q   <= 1'b0;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rnw_q   <= rnw_d;
      owner_q <= owner_d;
    end
  end

  // Outputs decode straight from registered state. Data outputs are zeroed
  // outside their phase so everything reads 0 while reset is held.
  always_comb begin
    ic_req_ready    = grant_any && !grant_dc;
    dc_req_ready    = grant_any && grant_dc;
    mem_cmd_valid   = (state_q == CMD);
    mem_cmd_rnw     = rnw_q;
    mem_cmd_addr    = addr_q;
    mem_wdata_valid = (state_q == WR) && dc_wdata_valid;
    dc_wdata_ready  = (state_q == WR) && mem_wdata_ready;
    mem_wdata       = (state_q == WR) ? dc_wdata : '0;
    ic_resp_valid   = rd_beat && !owner_q;
    dc_resp_valid   = rd_beat && owner_q;
    ic_resp_data    = (rd_beat && !owner_q) ? mem_rdata : '0;
    dc_resp_data    = (rd_beat && owner_q) ? mem_rdata : '0;
    ic_resp_last    = rd_beat && !owner_q && last_cnt;
    dc_resp_last    = rd_beat && owner_q && last_cnt;
    busy            = (state_q != IDLE);
    owner           = owner_q;
  end

endmodule
